// File: rtl/kbcmd_pkg.sv
// Shared constants and FSM state type for the keyboard command sequencer.
// Keyboard reply codes and the writer busy-rise window live here.
package kbcmd_pkg;
  localparam logic [7:0] KB_ACK    = 8'hFA;
  localparam logic [7:0] KB_RESEND = 8'hFE;
  localparam int BUSY_RISE_LIMIT   = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_WAIT_ACK
  } state_t;
endpackage

// File: rtl/kbcmd_if.sv
// Sequencer <-> PS/2 writer/reader handshake bundle.
// master = sequencer side, slave = writer/reader side.
interface kbcmd_if;
  logic [7:0] data;
  logic       dataload;
  logic       busy;
  logic       ps2error;
  logic       rx_valid;
  logic [7:0] rx_byte;

  modport master (
    output data, dataload,
    input  busy, ps2error, rx_valid, rx_byte
  );
  modport slave (
    input  data, dataload,
    output busy, ps2error, rx_valid, rx_byte
  );
endinterface

// File: rtl/kbcmd_debounce.sv
// One button channel: 2-flop synchroniser, shift history, registered
// one-cycle press strobe on a clean 0000_1..1 history pattern.
module kbcmd_debounce #(
  parameter int DEBOUNCE_LEN = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_bt,
  output logic o_press
);
  logic                    r_s1;
  logic                    r_s2;
  logic [DEBOUNCE_LEN-1:0] r_hist;
  logic                    w_hit;

  assign w_hit = (r_hist[DEBOUNCE_LEN-1 -: 4] == 4'b0000)
              && (&r_hist[DEBOUNCE_LEN-5:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_hist  <= '0;
      o_press <= 1'b0;
    end else begin
      r_s1    <= i_bt;
      r_s2    <= r_s1;
      r_hist  <= {r_hist[DEBOUNCE_LEN-2:0], r_s2};
      o_press <= w_hit;
    end
  end
endmodule

// File: rtl/kbcmd_sequencer.sv
// Front-panel buttons -> command FIFO -> PS/2 writer, with ACK/resend
// handling, retry budget and reply timeout.
import kbcmd_pkg::*;

module kbcmd_sequencer #(
  parameter int NBUTTONS     = 4,
  parameter int DEBOUNCE_LEN = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int ACK_TIMEOUT  = 50000,
  parameter int MAX_RETRIES  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NBUTTONS-1:0]           i_bt,
  input  logic [8*NBUTTONS-1:0]         i_cmd_table,
  kbcmd_if.master                       ps2,
  output logic [$clog2(FIFO_DEPTH):0]   o_pending,
  output logic                          o_ack_ok,
  output logic                          o_cmd_fail,
  output logic                          o_overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(ACK_TIMEOUT+1);
  localparam int RW = $clog2(MAX_RETRIES+2);
  localparam logic [TW-1:0] TMO  = TW'(ACK_TIMEOUT);
  localparam logic [RW-1:0] MAXR = RW'(MAX_RETRIES);
  localparam logic [2:0]    BRL  = 3'(BUSY_RISE_LIMIT-1);
  localparam logic [AW:0]   FULL = (AW+1)'(FIFO_DEPTH);

  logic [NBUTTONS-1:0] w_press;
  logic [NBUTTONS-1:0] r_req;
  logic [NBUTTONS-1:0] w_grant;
  logic                w_arb;
  logic [7:0]          w_arb_byte;

  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic w_full, w_empty, w_push, w_pop;

  state_t        r_state, w_next;
  logic [TW-1:0] r_timer;
  logic [RW-1:0] r_retries;
  logic [2:0]    r_bwait;
  logic          r_bseen;
  logic [7:0]    r_data;
  logic r_ack, r_fail, r_ovf;
  logic w_load, w_retry, w_inc, w_ack, w_fail;

  for (genvar g = 0; g < NBUTTONS; g++) begin : g_db
    kbcmd_debounce #(.DEBOUNCE_LEN(DEBOUNCE_LEN)) u_db (
      .clk     (clk),
      .rst     (rst),
      .i_bt    (i_bt[g]),
      .o_press (w_press[g])
    );
  end

  always_comb begin
    w_grant    = '0;
    w_arb      = 1'b0;
    w_arb_byte = 8'h00;
    for (int i = 0; i < NBUTTONS; i++) begin
      if (r_req[i] && !w_arb) begin
        w_grant[i] = 1'b1;
        w_arb      = 1'b1;
        w_arb_byte = i_cmd_table[8*i +: 8];
      end
    end
  end

  assign w_full  = (r_count == FULL);
  assign w_empty = (r_count == '0);
  // A full FIFO still accepts a push when the head leaves this cycle
  assign w_push  = w_arb && (!w_full || w_pop);

  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_retry = 1'b0;
    w_inc   = 1'b0;
    w_ack   = 1'b0;
    w_pop   = 1'b0;
    w_fail  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!w_empty && !ps2.busy) begin
          w_next = ST_LOAD;
          w_load = 1'b1;
        end
      end
      ST_LOAD: w_next = ST_SEND;
      ST_SEND: begin
        if (!r_bseen && !ps2.busy && r_bwait == BRL) begin
          w_retry = 1'b1;
        end else if (r_bseen && !ps2.busy) begin
          if (ps2.ps2error) w_retry = 1'b1;
          else              w_next  = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (ps2.rx_valid && ps2.rx_byte == KB_ACK) begin
          w_next = ST_IDLE;
          w_pop  = 1'b1;
          w_ack  = 1'b1;
        end else if ((ps2.rx_valid && ps2.rx_byte == KB_RESEND)
                     || r_timer == TMO) begin
          w_retry = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
    // Retries re-enter through IDLE so LOAD again waits for busy=0
    if (w_retry) begin
      w_next = ST_IDLE;
      if (r_retries < MAXR) begin
        w_inc = 1'b1;
      end else begin
        w_pop  = 1'b1;
        w_fail = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_req     <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_timer   <= '0;
      r_retries <= '0;
      r_bwait   <= '0;
      r_bseen   <= 1'b0;
      r_data    <= 8'h00;
      r_ack     <= 1'b0;
      r_fail    <= 1'b0;
      r_ovf     <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 8'h00;
    end else begin
      r_state <= w_next;
      r_ack   <= w_ack;
      r_fail  <= w_fail;
      r_ovf   <= |(w_press & r_req);
      r_req   <= (r_req & ~(w_push ? w_grant : '0))
               | (w_press & ~r_req);
      if (w_push) begin
        r_mem[r_wptr] <= w_arb_byte;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + {{AW{1'b0}}, w_push}
                         - {{AW{1'b0}}, w_pop};
      if (w_load) r_data <= r_mem[r_rptr];
      if (w_pop)      r_retries <= '0;
      else if (w_inc) r_retries <= r_retries + 1'b1;
      if (r_state == ST_WAIT_ACK) r_timer <= r_timer + 1'b1;
      else                        r_timer <= '0;
      if (r_state == ST_SEND) begin
        if (ps2.busy)     r_bseen <= 1'b1;
        else if (!r_bseen) r_bwait <= r_bwait + 1'b1;
      end else begin
        r_bseen <= 1'b0;
        r_bwait <= '0;
      end
    end
  end

  assign ps2.data     = r_data;
  assign ps2.dataload = (r_state == ST_LOAD);
  assign o_pending    = r_count;
  assign o_ack_ok     = r_ack;
  assign o_cmd_fail   = r_fail;
  assign o_overflow   = r_ovf;
endmodule

// File: tb/tb_kbcmd_sequencer.sv
// Bench for kbcmd_sequencer: scripted PS/2 writer/keyboard model plus
// a transaction scoreboard checked every cycle.
module tb_kbcmd_sequencer;
  localparam int DEPTH = 4;
  localparam int MAXR  = 2;
  localparam int C_ACK = 250;
  localparam int C_RES = 254;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  bt = 4'b0000;
  logic [31:0] cmd_table = 32'hF4EDF3EE;
  logic [2:0]  pending;
  logic        ack_ok, cmd_fail, overflow;
  logic        hold_busy = 1'b0;

  int n_tests = 0, n_fail = 0, cyc = 0;
  int n_dl = 0, n_ack = 0, n_cf = 0, n_ovf = 0;
  int attempts = 0, ack_t = 0;
  bit exp_ack = 0, exp_fail = 0, prev_dl = 0;
  logic [7:0] exp_q[$];
  int wscript[$], mscript[$], dl_t[$];

  kbcmd_if bus();

  kbcmd_sequencer #(
    .NBUTTONS(4), .DEBOUNCE_LEN(16), .FIFO_DEPTH(DEPTH),
    .ACK_TIMEOUT(100), .MAX_RETRIES(MAXR)
  ) dut (
    .clk(clk), .rst(rst), .i_bt(bt), .i_cmd_table(cmd_table),
    .ps2(bus), .o_pending(pending), .o_ack_ok(ack_ok),
    .o_cmd_fail(cmd_fail), .o_overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic press(input logic [3:0] m);
    bt = bt | m;
    repeat (30) tick();
    bt = bt & ~m;
    repeat (20) tick();
  endtask

  task automatic script(input int c);
    wscript.push_back(c);
    mscript.push_back(c);
  endtask

  task automatic clr_counts();
    n_dl = 0; n_ack = 0; n_cf = 0; n_ovf = 0;
    dl_t.delete();
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while ((exp_q.size() != 0 || pending != 0) && k < 3000) begin
      tick();
      k++;
    end
    chk({nm, "_done"}, 32'(k < 3000), 1);
    repeat (5) tick();
  endtask

  // Writer + keyboard: codes -1 ps2error, -2 busy never rises,
  // 0 no reply, else reply byte after transmit.
  initial begin
    int code;
    bus.busy = 1'b0; bus.ps2error = 1'b0;
    bus.rx_valid = 1'b0; bus.rx_byte = 8'h00;
    forever begin
      tick();
      bus.busy = hold_busy;
      if (bus.dataload && !hold_busy) begin
        code = (wscript.size() != 0) ? wscript.pop_front() : C_ACK;
        if (code != -2) begin
          tick(); bus.busy = 1'b1;
          repeat (20) tick();
          bus.busy = 1'b0;
          bus.ps2error = (code == -1);
          tick(); bus.ps2error = 1'b0;
          if (code > 0) begin
            repeat (2) tick();
            bus.rx_valid = 1'b1;
            bus.rx_byte  = 8'(code);
            tick(); bus.rx_valid = 1'b0;
          end
        end
      end
    end
  end

  // Scoreboard: commands leave in queue order; each attempt consumes
  // one script entry; ACK ends it, MAXR+1 failed attempts abandon it.
  initial begin
    int mc;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete(); mscript.delete();
        attempts = 0; exp_ack = 0; exp_fail = 0; prev_dl = 0;
        continue;
      end
      if (bus.dataload) begin
        n_dl++;
        dl_t.push_back(cyc);
        chk("dl_busy", 32'(bus.busy), 0);
        chk("dl_b2b", 32'(prev_dl), 0);
        chk("dl_early", 32'(exp_ack | exp_fail), 0);
        chk("dl_data", 32'(bus.data),
            (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'h100);
        mc = (mscript.size() != 0) ? mscript.pop_front() : C_ACK;
        attempts++;
        if (mc == C_ACK) exp_ack = 1;
        else if (attempts == MAXR + 1) exp_fail = 1;
      end
      if (ack_ok) begin
        n_ack++;
        ack_t = cyc;
        chk("ack_exp", 32'(exp_ack), 1);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        attempts = 0; exp_ack = 0;
      end
      if (cmd_fail) begin
        n_cf++;
        chk("fail_exp", 32'(exp_fail), 1);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        attempts = 0; exp_fail = 0;
      end
      if (overflow) n_ovf++;
      chk("pend_range", 32'(pending <= DEPTH), 1);
      prev_dl = bus.dataload;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    chk("rst_data", 32'(bus.data), 0);
    chk("rst_dl", 32'(bus.dataload), 0);
    chk("rst_pend", 32'(pending), 0);
    chk("rst_pulses", {29'd0, ack_ok, cmd_fail, overflow}, 0);
    rst = 1'b0;
    repeat (3) tick();

    // T1: bt[2] -> 0xED, exact press/enqueue/load latency
    clr_counts();
    exp_q.push_back(8'hED);
    bt = 4'b0100;
    repeat (16) @(posedge clk);
    #1 chk("t1_pend_e15", 32'(pending), 0);
    tick();
    chk("t1_pend_e16", 32'(pending), 1);
    chk("t1_dl_e16", 32'(bus.dataload), 0);
    tick();
    chk("t1_dl_e17", 32'(bus.dataload), 1);
    chk("t1_data_e17", 32'(bus.data), 32'hED);
    repeat (12) tick();
    bt = 4'b0000;
    repeat (20) tick();
    wait_idle("t1");
    chk("t1_ndl", n_dl, 1);
    chk("t1_nack", n_ack, 1);
    chk("t1_ack_lat", ack_t - dl_t[0], 25);
    chk("t1_pend", 32'(pending), 0);

    // T2: ch0 and ch3 together, ch0 first
    clr_counts();
    exp_q.push_back(8'hEE);
    exp_q.push_back(8'hF4);
    press(4'b1001);
    wait_idle("t2");
    chk("t2_ndl", n_dl, 2);
    chk("t2_nack", n_ack, 2);
    chk("t2_novf", n_ovf, 0);

    // T3: resend twice then ACK
    clr_counts();
    exp_q.push_back(8'hF3);
    script(C_RES); script(C_RES); script(C_ACK);
    press(4'b0010);
    wait_idle("t3");
    chk("t3_ndl", n_dl, 3);
    chk("t3_nack", n_ack, 1);
    chk("t3_nfail", n_cf, 0);

    // T3b: writer never raises busy, then normal
    clr_counts();
    exp_q.push_back(8'hEE);
    script(-2); script(C_ACK);
    press(4'b0001);
    wait_idle("t3b");
    chk("t3b_ndl", n_dl, 2);
    chk("t3b_gap", dl_t[1] - dl_t[0], 6);
    chk("t3b_nack", n_ack, 1);

    // T4: silent keyboard, abandon after timeouts, queue advances
    clr_counts();
    exp_q.push_back(8'hEE);
    exp_q.push_back(8'hF3);
    script(0); script(0); script(0); script(C_ACK);
    press(4'b0011);
    wait_idle("t4");
    chk("t4_ndl", n_dl, 4);
    chk("t4_gap1", dl_t[1] - dl_t[0], 124);
    chk("t4_gap2", dl_t[2] - dl_t[1], 124);
    chk("t4_nfail", n_cf, 1);
    chk("t4_nack", n_ack, 1);

    // T5: busy held, queue fills, repeat press overflows
    clr_counts();
    hold_busy = 1'b1;
    repeat (2) tick();
    exp_q.push_back(8'hEE); exp_q.push_back(8'hF3);
    exp_q.push_back(8'hED); exp_q.push_back(8'hF4);
    exp_q.push_back(8'hF3);
    press(4'b0001); press(4'b0010);
    press(4'b0100); press(4'b1000);
    chk("t5_pend_full", 32'(pending), 4);
    press(4'b0010);
    chk("t5_pend_sat", 32'(pending), 4);
    chk("t5_ovf_none", n_ovf, 0);
    press(4'b0010);
    chk("t5_ovf", n_ovf, 1);
    chk("t5_ndl_held", n_dl, 0);
    hold_busy = 1'b0;
    wait_idle("t5");
    chk("t5_ndl", n_dl, 5);
    chk("t5_nack", n_ack, 5);

    // T6: reset during WAIT_ACK
    clr_counts();
    exp_q.push_back(8'hF3);
    script(0);
    press(4'b0010);
    chk("t6_pend_pre", 32'(pending), 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_data", 32'(bus.data), 0);
    chk("t6_dl", 32'(bus.dataload), 0);
    chk("t6_pend", 32'(pending), 0);
    chk("t6_pulses", {29'd0, ack_ok, cmd_fail, overflow}, 0);
    wscript.delete();
    repeat (3) tick();
    rst = 1'b0;
    clr_counts();
    repeat (150) tick();
    chk("t6_quiet", n_dl + n_ack + n_cf, 0);
    exp_q.push_back(8'hED);
    press(4'b0100);
    wait_idle("t6");
    chk("t6_ndl", n_dl, 1);
    chk("t6_nack", n_ack, 1);
    chk("t6_nfail", n_cf, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/kbcmd_sequencer.md
# kbcmd_sequencer

Parametrised keyboard command sequencer sitting between front-panel buttons and the PS/2 host-to-keyboard writer. It debounces N buttons, maps each press to a programmable command byte, and queues commands in a small FIFO so presses are not lost while the port is busy. It issues each command through the writer's dataload/busy handshake, then waits for the keyboard's ACK (0xFA), retrying on resend (0xFE), transmit error or timeout.

## Interface

- NBUTTONS, 4, number of button channels (1..8)
- DEBOUNCE_LEN, 16, debounce history length in clk cycles (>= 8)
- FIFO_DEPTH, 4, command queue entries (power of 2, >= 2)
- ACK_TIMEOUT, 50000, clk cycles to wait for a reply byte after transmit
- MAX_RETRIES, 2, resends before a command is abandoned

- clk  in  1  system clock, same domain as the PS/2 writer and reader
- rst  in  1  asynchronous, active-high reset
- bt  in  NBUTTONS  raw button inputs, asynchronous, active-high
- cmd_table  in  8*NBUTTONS  command byte for channel i at [8i+7:8i]; sampled at enqueue
- busy  in  1  writer busy
- ps2error  in  1  writer error flag, sampled when busy falls
- rx_valid  in  1  one-cycle strobe, received byte valid
- rx_byte  in  8  received byte
- data  out  8  byte to transmit; holds last loaded value
- dataload  out  1  one-cycle load strobe to the writer
- pending  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- ack_ok  out  1  one-cycle pulse, command acknowledged
- cmd_fail  out  1  one-cycle pulse, command abandoned
- overflow  out  1  one-cycle pulse, press dropped

## Operation

- Per channel: 2-flop synchroniser, DEBOUNCE_LEN-bit shift history. Press strobe when top 4 history bits are 0 and remaining DEBOUNCE_LEN-4 bits are 1; strobe is registered, one cycle wide.
- Press sets channel request latch. Press on a channel whose latch is already set: dropped, overflow pulses.
- Arbiter: each cycle, if FIFO not full, lowest-index set latch is enqueued (byte from cmd_table) and its latch cleared. One enqueue per cycle. FIFO full: latches wait.
- FSM states: IDLE, LOAD, SEND, WAIT_ACK.
  - IDLE: FIFO non-empty and busy=0 -> LOAD.
  - LOAD: data <= FIFO head, dataload=1 for this cycle -> SEND.
  - SEND: busy must rise within 4 cycles of dataload, else treated as error. On busy fall: ps2error=1 -> retry; else -> WAIT_ACK, timer cleared.
  - WAIT_ACK: rx_valid with 0xFA -> pop, ack_ok, IDLE. rx_valid with 0xFE -> retry. Other bytes ignored. Timer reaches ACK_TIMEOUT -> retry.
  - Retry: retries < MAX_RETRIES -> increment, wait busy=0, LOAD with same head. Otherwise pop, cmd_fail, IDLE.
- Retry count cleared on every pop.
- Enqueue and pop in the same cycle: pending unchanged; enqueue allowed when full only if a pop occurs that cycle.

## Timing

- Reset (async assert, outputs valid immediately): data=0x00, dataload=0, pending=0, ack_ok=0, cmd_fail=0, overflow=0; FSM IDLE; histories, latches, FIFO, retry count, timer cleared.
- Reset mid-transaction: command lost, no cmd_fail pulse.
- bt sampled high first at edge 0, stable: press strobe high after edge DEBOUNCE_LEN-2; latch after next edge; enqueue next edge; LOAD entered next edge if IDLE and busy=0.
- dataload never asserts while busy=1 or in back-to-back cycles.
- Button held through reset: press reported after DEBOUNCE_LEN-2 cycles (history starts at 0).
- Timer counts only in WAIT_ACK; width $clog2(ACK_TIMEOUT+1).

## Structure

- Package kbcmd_pkg: KB_ACK=8'hFA, KB_RESEND=8'hFE, FSM state enum, BUSY_RISE_LIMIT=4.
- Sub-module kbcmd_debounce (synchroniser + history + strobe, parameter DEBOUNCE_LEN), one instance per channel. FIFO, arbiter and FSM inline.

## Test plan

- bt[2] pulse 30 cycles, cmd_table[23:16]=0xED, writer model busy 20 cycles, reply 0xFA -> one dataload with data=0xED, ack_ok once, pending back to 0.
- bt[0] and bt[3] press same cycle -> channel 0 byte sent first, channel 3 second, both acked, no overflow.
- Reply 0xFE twice then 0xFA, MAX_RETRIES=2 -> three dataloads of same byte, one ack_ok, no cmd_fail.
- No reply, ACK_TIMEOUT=100 -> 3 dataloads spaced by timeout, one cmd_fail, FIFO advances.
- busy held 1, 6 presses across channels, FIFO_DEPTH=4 -> pending saturates at 4, repeat press on latched channel pulses overflow, all queued bytes later sent in order.
- rst asserted during WAIT_ACK -> all outputs 0 immediately, no ack_ok/cmd_fail, next press handled normally.
